// File: rtl/delta_pkg.sv
// Shared spike encodings and the token type for the delta-modulation encoder.
package delta_pkg;

  typedef logic [1:0] spike_t;

  localparam spike_t SPIKE_NONE = 2'b00;
  localparam spike_t SPIKE_ON   = 2'b01;
  localparam spike_t SPIKE_OFF  = 2'b11;

endpackage

// File: rtl/delta_compare.sv
// Combinational spike decision: compares a sample against its channel reference
// using a WIDTH+1 signed difference so full-range swings never wrap.
module delta_compare
  import delta_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] ref_val,
  input  logic [WIDTH-1:0] threshold,
  input  logic             off_en,
  output spike_t           spike,
  output logic             update
);

  logic signed [WIDTH:0] diff;
  logic signed [WIDTH:0] thr_pos;
  logic signed [WIDTH:0] thr_neg;

  always_comb begin
    diff    = $signed({1'b0, data}) - $signed({1'b0, ref_val});
    thr_pos = $signed({1'b0, threshold});
    // -threshold always fits: the most negative threshold magnitude is 2^WIDTH-1
    thr_neg = -thr_pos;
    spike   = SPIKE_NONE;
    update  = 1'b0;
    if (diff > thr_pos) begin
      spike  = SPIKE_ON;
      update = 1'b1;
    end else if (off_en && (diff < thr_neg)) begin
      spike  = SPIKE_OFF;
      update = 1'b1;
    end
  end

endmodule

// File: rtl/delta_encoder.sv
// Multi-channel streaming delta-modulation spike encoder with per-channel
// reference, priming, refractory counter and a single registered output stage.
module delta_encoder
  import delta_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 4,
  parameter int REFRACT_W = 4,
  parameter int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH_W-1:0]      in_chan,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [WIDTH-1:0]     threshold,
  input  logic                 off_en,
  input  logic [REFRACT_W-1:0] refractory,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH_W-1:0]      out_chan,
  output spike_t               out_spike
);

  localparam logic [CH_W:0] CHAN_LIM = CHANNELS[CH_W:0];

  logic [WIDTH-1:0]     ref_q    [CHANNELS];
  logic [REFRACT_W-1:0] rcnt_q   [CHANNELS];
  logic [CHANNELS-1:0]  primed_q;

  logic                 accept;
  logic                 chan_ok;
  logic                 take;
  logic [CH_W-1:0]      idx;
  logic [WIDTH-1:0]     cur_ref;
  logic [REFRACT_W-1:0] cur_rcnt;
  logic                 cur_primed;
  spike_t               cmp_spike;
  logic                 cmp_update;
  spike_t               tok_spike;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign chan_ok  = ({1'b0, in_chan} < CHAN_LIM);
  assign take     = accept && chan_ok;
  // Out-of-range channels are dropped; steer the read to a legal entry anyway
  assign idx      = chan_ok ? in_chan : '0;

  assign cur_ref    = ref_q[idx];
  assign cur_rcnt   = rcnt_q[idx];
  assign cur_primed = primed_q[idx];

  delta_compare #(.WIDTH(WIDTH)) u_cmp (
    .data      (in_data),
    .ref_val   (cur_ref),
    .threshold (threshold),
    .off_en    (off_en),
    .spike     (cmp_spike),
    .update    (cmp_update)
  );

  always_comb begin
    tok_spike = SPIKE_NONE;
    if (cur_primed && (cur_rcnt == '0)) tok_spike = cmp_spike;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        ref_q[c]  <= '0;
        rcnt_q[c] <= '0;
      end
      primed_q <= '0;
    end else if (take) begin
      if (!cur_primed) begin
        ref_q[idx]    <= in_data;
        primed_q[idx] <= 1'b1;
      end else if (cur_rcnt != '0) begin
        rcnt_q[idx] <= cur_rcnt - 1'b1;
      end else if (cmp_update) begin
        ref_q[idx]  <= in_data;
        rcnt_q[idx] <= refractory;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_chan  <= '0;
      out_spike <= SPIKE_NONE;
    end else if (take) begin
      out_valid <= 1'b1;
      out_chan  <= in_chan;
      out_spike <= tok_spike;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_delta_encoder.sv
// Directed bench for delta_encoder: hand-computed tokens for priming, ON/OFF,
// refractory, full-range, interleave, backpressure and reset cases.
module tb_delta_encoder;
  import delta_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_chan;
  logic [7:0] in_data;
  logic [7:0] threshold;
  logic       off_en;
  logic [3:0] refractory;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_chan;
  spike_t     out_spike;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  delta_encoder #(.WIDTH(8), .CHANNELS(4), .REFRACT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_chan    (in_chan),
    .in_data    (in_data),
    .threshold  (threshold),
    .off_en     (off_en),
    .refractory (refractory),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_chan   (out_chan),
    .out_spike  (out_spike)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one sample, clock it in, then check the resulting token.
  task automatic send(input logic [1:0] ch, input logic [7:0] d, input logic oe,
                      input logic [1:0] exp_spike, input string tag);
    in_valid = 1'b1;
    in_chan  = ch;
    in_data  = d;
    off_en   = oe;
    @(posedge clk);
    #1;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_chan"},  32'(out_chan),  32'(ch));
    check({tag, "_spike"}, 32'(out_spike), 32'(exp_spike));
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_chan = '0;
    in_data = '0;
    threshold = 8'd10;
    off_en = 1'b0;
    refractory = '0;
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_chan",  32'(out_chan),  32'd0);
    check("rst_out_spike", 32'(out_spike), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Basic ON
    threshold = 8'd10; refractory = 4'd0;
    send(2'd0, 8'd100, 1'b0, SPIKE_NONE, "on_prime");
    send(2'd0, 8'd111, 1'b0, SPIKE_ON,   "on_diff11");
    send(2'd0, 8'd121, 1'b0, SPIKE_NONE, "on_diff10");

    // OFF gating
    send(2'd1, 8'd50, 1'b1, SPIKE_NONE, "off_prime");
    send(2'd1, 8'd30, 1'b1, SPIKE_OFF,  "off_m20");
    send(2'd1, 8'd10, 1'b0, SPIKE_NONE, "off_gated");
    send(2'd1, 8'd5,  1'b1, SPIKE_OFF,  "off_m25");
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_valid_low", 32'(out_valid), 32'd0);

    // Refractory
    do_reset();
    threshold = 8'd10; refractory = 4'd2;
    send(2'd0, 8'd0,  1'b0, SPIKE_NONE, "rf_prime");
    send(2'd0, 8'd20, 1'b0, SPIKE_ON,   "rf_on1");
    send(2'd0, 8'd40, 1'b0, SPIKE_NONE, "rf_hold1");
    send(2'd0, 8'd60, 1'b0, SPIKE_NONE, "rf_hold2");
    send(2'd0, 8'd80, 1'b0, SPIKE_ON,   "rf_on2");

    // Full-range extremes
    do_reset();
    threshold = 8'd254; refractory = 4'd0;
    send(2'd3, 8'd0,   1'b1, SPIKE_NONE, "ext_prime");
    send(2'd3, 8'd255, 1'b1, SPIKE_ON,   "ext_up");
    send(2'd3, 8'd0,   1'b1, SPIKE_OFF,  "ext_down");

    // Interleave, back-to-back
    do_reset();
    threshold = 8'd10; refractory = 4'd0;
    send(2'd0, 8'd100, 1'b1, SPIKE_NONE, "il_p0");
    send(2'd1, 8'd50,  1'b1, SPIKE_NONE, "il_p1");
    send(2'd2, 8'd200, 1'b1, SPIKE_NONE, "il_p2");
    send(2'd3, 8'd7,   1'b1, SPIKE_NONE, "il_p3");
    send(2'd0, 8'd120, 1'b1, SPIKE_ON,   "il_c0");
    send(2'd1, 8'd40,  1'b1, SPIKE_NONE, "il_c1_eq");
    send(2'd2, 8'd215, 1'b1, SPIKE_ON,   "il_c2");

    // Backpressure: ch3 sample waits while the ch2 token is stalled
    out_ready = 1'b0;
    in_valid = 1'b1; in_chan = 2'd3; in_data = 8'd30; off_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_chan",  32'(out_chan),  32'd2);
      check("bp_spike", 32'(out_spike), 32'(SPIKE_ON));
    end
    out_ready = 1'b1;
    send(2'd3, 8'd30, 1'b1, SPIKE_ON, "bp_release");
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_drain_valid", 32'(out_valid), 32'd0);

    // Reset mid-stream with a pending token
    out_ready = 1'b0;
    send(2'd0, 8'd10, 1'b1, SPIKE_OFF, "mr_pending");
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mr_valid_async", 32'(out_valid), 32'd0);
    check("mr_spike_async", 32'(out_spike), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    send(2'd0, 8'd200, 1'b1, SPIKE_NONE, "mr_reprime");
    in_valid = 1'b0;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
